// File: rtl/frame_buffer_gray.sv
// Frame buffer and grayscale converter: captures one RGB frame into internal RAM,
// then streams it back out as 8-bit grayscale under controller on_off/rw handshake.
module frame_buffer_gray #(
  parameter  int IMG_W = 64,
  parameter  int IMG_H = 64,
  localparam int N     = IMG_W * IMG_H,
  localparam int AW    = $clog2(N)
) (
  input  logic          clk,
  input  logic          erst,
  input  logic          on_off,
  input  logic          rw,
  input  logic          pix_valid,
  input  logic [23:0]   pix_rgb,
  output logic          pix_ready,
  output logic          gray_valid,
  output logic [7:0]    gray_data,
  output logic [AW-1:0] gray_addr,
  output logic          done
);

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CAPTURE,
    S_CAP_DONE,
    S_WAIT_RW,
    S_CONVERT,
    S_DRAIN1,
    S_DRAIN2,
    S_CONV_DONE,
    S_WAIT_OFF
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en, abort;
  logic [23:0]   ram [N];
  logic [23:0]   ram_q;
  logic          v1;
  logic [AW-1:0] a1;
  logic [7:0]    gray_next;

  assign abort     = (state != S_IDLE) && !on_off;
  assign wr_en     = (state == S_CAPTURE) && pix_valid;
  assign rd_en     = (state == S_CONVERT);
  assign pix_ready = (state == S_CAPTURE);
  assign done      = (state == S_CAP_DONE) || (state == S_CONV_DONE);

  // Weights sum to 256, so the 16-bit sum never overflows; >>8 truncates.
  assign gray_next = 8'((16'd77  * {8'd0, ram_q[23:16]}
                       + 16'd150 * {8'd0, ram_q[15:8]}
                       + 16'd29  * {8'd0, ram_q[7:0]}) >> 8);

  always_comb begin
    state_n = state;
    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:      if (on_off) state_n = rw ? S_CAPTURE : S_CONVERT;
        S_CAPTURE:   if (pix_valid && (wr_ptr == LAST)) state_n = S_CAP_DONE;
        S_CAP_DONE:  state_n = S_WAIT_RW;
        S_WAIT_RW:   if (!rw) state_n = S_CONVERT;
        S_CONVERT:   if (rd_ptr == LAST) state_n = S_DRAIN1;
        S_DRAIN1:    state_n = S_DRAIN2;
        S_DRAIN2:    state_n = S_CONV_DONE;
        S_CONV_DONE: state_n = S_WAIT_OFF;
        S_WAIT_OFF:  state_n = S_WAIT_OFF;
        default:     state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (erst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      v1         <= 1'b0;
      a1         <= '0;
      gray_valid <= 1'b0;
      gray_data  <= '0;
      gray_addr  <= '0;
    end else begin
      state <= state_n;
      if (abort || (state == S_IDLE)) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + AW'(1);
        if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + AW'(1);
      end
      // Two-stage pipeline: RAM read, then weighted sum; abort flushes both stages.
      v1         <= rd_en && !abort;
      a1         <= rd_ptr;
      gray_valid <= v1 && !abort;
      if (v1) begin
        gray_data <= gray_next;
        gray_addr <= a1;
      end
    end
  end

  // RAM contents survive reset and abort.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_ptr] <= pix_rgb;
    ram_q <= ram[rd_ptr];
  end

endmodule

// File: tb/tb_frame_buffer_gray.sv
// Scoreboard bench for frame_buffer_gray on a 4x4 frame: capture, convert,
// arithmetic corners, overrun, abort, mid-convert reset and handshake holds.
module tb_frame_buffer_gray;

  localparam int NP = 16;

  logic        clk = 1'b0;
  logic        erst = 1'b1;
  logic        on_off = 1'b0;
  logic        rw = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic        pix_ready, gray_valid, done;
  logic [7:0]  gray_data;
  logic [3:0]  gray_addr;

  frame_buffer_gray #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .erst(erst), .on_off(on_off), .rw(rw),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_ready(pix_ready),
    .gray_valid(gray_valid), .gray_data(gray_data), .gray_addr(gray_addr),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t        sb[$];
  logic [23:0] mem_model [NP];
  logic [23:0] src [20];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_done = -1;
  bit          prev_done = 1'b0;
  int          known_gray [6] = '{8'hFF, 8'h00, 8'h4C, 8'h95, 8'h1C, 8'h80};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int gray_of(input logic [23:0] p);
    return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (gray_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("gray_unexpected", gray_valid, 0);
      end else begin
        e = sb.pop_front();
        check_val("gray_data", gray_data, e.data);
        check_val("gray_addr", gray_addr, e.addr);
        check_val("gray_cycle", cyc, e.cyc);
      end
    end
    if (done === 1'b1) begin
      check_val("done_twice", prev_done, 0);
      done_cnt++;
      last_done = cyc;
    end
    prev_done = (done === 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input int npix, input bit gap);
    int d0;
    d0 = done_cnt;
    on_off = 1'b1;
    rw = 1'b1;
    tick();
    check_val("ready_rise", pix_ready, 1);
    for (int i = 0; i < npix; i++) begin
      pix_valid = 1'b1;
      pix_rgb = src[i];
      if (i < NP) mem_model[i] = src[i];
      tick();
      if (i == NP - 1) begin
        check_val("cap_done", done, 1);
        check_val("ready_low_at_done", pix_ready, 0);
      end else if (i >= NP) begin
        check_val("ready_overrun", pix_ready, 0);
      end
      if (gap) begin
        pix_valid = 1'b0;
        tick();
      end
    end
    pix_valid = 1'b0;
    tick();
    if (npix >= NP) check_val("cap_done_count", done_cnt - d0, 1);
  endtask

  task automatic push_frame(input int c, input bit use_known);
    exp_t e;
    for (int k = 0; k < NP; k++) begin
      e.addr = k;
      e.data = (use_known && k < 6) ? known_gray[k] : gray_of(mem_model[k]);
      e.cyc  = c + 2 + k;
      sb.push_back(e);
    end
  endtask

  task automatic convert(input bit use_known);
    int c, d0;
    d0 = done_cnt;
    on_off = 1'b1;
    rw = 1'b0;
    c = cyc + 1;
    push_frame(c, use_known);
    repeat (NP + 4) tick();
    check_val("conv_drained", sb.size(), 0);
    check_val("conv_done_cycle", last_done, c + NP + 2);
    check_val("conv_done_count", done_cnt - d0, 1);
    rw = 1'b1;
    repeat (5) begin
      tick();
      check_val("wait_off_hold", pix_ready, 0);
    end
    check_val("wait_off_no_done", done_cnt - d0, 1);
    on_off = 1'b0;
    tick();
    on_off = 1'b1;
    tick();
    check_val("idle_after_off", pix_ready, 1);
    on_off = 1'b0;
    tick();
  endtask

  task automatic fill_random();
    for (int i = 0; i < 20; i++) src[i] = 24'($urandom);
  endtask

  initial begin
    int d0;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, c;
    repeat (2) tick();
    erst = 1'b0;
    tick();
    check_val("rst_pix_ready", pix_ready, 0);
    check_val("rst_gray_valid", gray_valid, 0);
    check_val("rst_gray_data", gray_data, 0);
    check_val("rst_gray_addr", gray_addr, 0);
    check_val("rst_done", done, 0);

    // Frame 1: arithmetic corners then random, gapped pixel strobe.
    fill_random();
    src[0] = 24'hFFFFFF; src[1] = 24'h000000; src[2] = 24'hFF0000;
    src[3] = 24'h00FF00; src[4] = 24'h0000FF; src[5] = 24'h808080;
    capture(NP, 1'b1);
    d0 = done_cnt;
    repeat (10) begin
      tick();
      check_val("wait_rw_no_conv", gray_valid, 0);
    end
    check_val("wait_rw_no_done", done_cnt - d0, 0);
    convert(1'b1);

    // Frame 2: continuous strobe for 20 cycles, only 16 written.
    fill_random();
    capture(20, 1'b0);
    convert(1'b0);

    // Reset in the middle of a re-conversion of the stored frame.
    d0 = done_cnt;
    on_off = 1'b1;
    rw = 1'b0;
    c = cyc + 1;
    push_frame(c, 1'b0);
    repeat (6) tick();
    erst = 1'b1;
    tick();
    sb.delete();
    tick();
    erst = 1'b0;
    on_off = 1'b0;
    check_val("midrst_pix_ready", pix_ready, 0);
    check_val("midrst_gray_valid", gray_valid, 0);
    check_val("midrst_gray_data", gray_data, 0);
    check_val("midrst_gray_addr", gray_addr, 0);
    check_val("midrst_done", done, 0);
    repeat (3) tick();
    check_val("midrst_no_done", done_cnt - d0, 0);

    // Abort after 7 pixels, then a full restart must write from address 0.
    fill_random();
    d0 = done_cnt;
    capture(7, 1'b0);
    on_off = 1'b0;
    tick();
    check_val("abort_ready", pix_ready, 0);
    check_val("abort_done", done, 0);
    tick();
    check_val("abort_no_done", done_cnt - d0, 0);
    fill_random();
    capture(NP, 1'b1);
    convert(1'b0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
